uart_tx_arbiter: RTL and testbench

- Shares one uart_tx byte transmitter between NUM_REQ independent requesters using round-robin arbitration.
- Packet locking: a granted requester keeps the transmitter until its byte flagged last has been sent.
- Sequences the transmitter's en/rdy handshake byte by byte: en must stay high for the whole frame and must drop exactly when rdy returns high.
- Sits between the debug/report sources and the single serial output pin.

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM_REQ requesters.
// A granted requester keeps the link until its byte flagged last has been sent.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_rdy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               locked_q, locked_d;

    logic [7:0]         req_byte [NUM_REQ];
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte
        assign req_byte[g] = req_data[8*g +: 8];
    end

    // Winner: the locked owner only, else first valid at or above rr_ptr with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (locked_q) begin
            win_found = req_valid[owner_q];
            win_idx   = owner_q;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
                if (cand >= NUM_REQ_W) begin
                    cand = cand - NUM_REQ_W;
                end
                if (!win_found && req_valid[cand[PTR_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = cand[PTR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ack_d     = '0;
        tx_data_d = tx_data_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        locked_d  = locked_q;
        tx_en     = 1'b0;
        case (state_q)
            IDLE: begin
                // A transmitter still finishing a frame from before reset must drain first.
                if (tx_rdy && win_found) begin
                    tx_data_d = req_byte[win_idx];
                    ack_d     = NUM_REQ'(1) << win_idx;
                    grant_d   = NUM_REQ'(1) << win_idx;
                    owner_d   = win_idx;
                    state_d   = LOAD;
                    if (req_last[win_idx]) begin
                        locked_d = 1'b0;
                        rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
                    end else begin
                        locked_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                tx_en   = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tx_en = 1'b1;
                if (!tx_rdy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // en falls in the same cycle rdy returns so uart_tx cannot restart.
                tx_en = ~tx_rdy;
                if (tx_rdy) begin
                    state_d = IDLE;
                    if (!locked_q) begin
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            tx_data_q <= '0;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            tx_data_q <= tx_data_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            locked_q  <= locked_d;
        end
    end

    assign grant   = grant_q;
    assign req_ack = ack_q;
    assign tx_data = tx_data_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx (4 clocks/bit), line receiver and byte scoreboard.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] gap;
    } item_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   grant;
    logic            busy;
    logic            tx_en;
    logic [7:0]      tx_data;
    logic            tx_rdy = 1'b1;

    logic            line = 1'b1;
    logic            m_busy = 1'b0;
    logic [9:0]      m_shift = '0;
    int              m_bit = 0;
    int              m_cnt = 0;

    item_t           rq [NR][$];
    int              wait_cnt [NR];
    int              ack_cnt [NR];
    logic [7:0]      exp_q [$];
    int              checks = 0;
    int              errors = 0;
    logic            prev_rdy = 1'b1;
    logic            prev_busy = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .grant     (grant),
        .busy      (busy),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_rdy    (tx_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // uart_tx model: not reset by rst; starts a frame on en while ready, rdy returns after the stop bit.
    always @(posedge clk) begin
        if (!m_busy) begin
            if (tx_en === 1'b1) begin
                m_busy  <= 1'b1;
                m_shift <= {1'b1, tx_data, 1'b0};
                m_bit   <= 0;
                m_cnt   <= 0;
                tx_rdy  <= 1'b0;
                line    <= 1'b0;
            end
        end else if (m_cnt == 3) begin
            m_cnt <= 0;
            if (m_bit == 9) begin
                m_busy <= 1'b0;
                tx_rdy <= 1'b1;
                line   <= 1'b1;
            end else begin
                m_bit <= m_bit + 1;
                line  <= m_shift[m_bit + 1];
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Line receiver: samples mid-bit and compares against the scoreboard.
    initial begin
        logic [7:0] rx;
        logic       start_b;
        logic       stop_b;
        logic [7:0] exp_b;
        forever begin
            @(posedge clk); #1;
            if (line === 1'b0) begin
                repeat (2) @(posedge clk);
                #1 start_b = line;
                for (int j = 0; j < 8; j++) begin
                    repeat (4) @(posedge clk);
                    #1 rx[j] = line;
                end
                repeat (4) @(posedge clk);
                #1 stop_b = line;
                check("start_bit", 32'(start_b), 32'd0);
                check("stop_bit", 32'(stop_b), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("frame_byte", 32'(rx), 32'(exp_b));
                end
            end
        end
    end

    // Requester drivers: present queued bytes, hold until ack, optional idle gap before each byte.
    initial begin
        item_t it;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ack[i]) begin
                    wait_cnt[i] = 0;
                    if (rq[i].size() > 0 && rq[i][0].gap == 8'd0) begin
                        it = rq[i].pop_front();
                        req_data[i*8 +: 8] = it.data;
                        req_last[i] = it.last;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if (!req_valid[i] && rq[i].size() > 0) begin
                    if (wait_cnt[i] >= int'(rq[i][0].gap)) begin
                        it = rq[i].pop_front();
                        req_valid[i] = 1'b1;
                        req_data[i*8 +: 8] = it.data;
                        req_last[i] = it.last;
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                    end
                end
            end
        end
    end

    // Handshake monitor: grant at ack, en low when rdy returns, en with rdy only right after IDLE.
    initial begin
        for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (req_ack[i] === 1'b1) begin
                    ack_cnt[i]++;
                    check("grant_at_ack", 32'(grant), 32'(1) << i);
                end
            end
            if (tx_rdy && !prev_rdy) check("en_drop_on_rdy", 32'(tx_en), 32'd0);
            if (tx_en === 1'b1 && tx_rdy) check("en_only_after_idle", 32'(prev_busy), 32'd0);
            prev_rdy  = tx_rdy;
            prev_busy = busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_req(input int r, input logic [7:0] d, input logic l,
                            input logic [7:0] g, input logic expect_it);
        item_t it;
        it.data = d;
        it.last = l;
        it.gap  = g;
        rq[r].push_back(it);
        if (expect_it) exp_q.push_back(d);
    endtask

    function automatic logic pending();
        logic p = 1'b0;
        for (int i = 0; i < NR; i++) if (rq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || pending() || busy !== 1'b0 || tx_rdy !== 1'b1 ||
                req_valid != '0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n >= 3000), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_grant_idle"}, 32'(grant), 32'd0);
    endtask

    task automatic wait_ack(input int r, input string tag);
        int n = 0;
        while (req_ack[r] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n >= 500), 32'd0);
    endtask

    task automatic wait_rdy_low(input string tag);
        int n = 0;
        while (tx_rdy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n >= 500), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int   n;
        int   ack2;
        logic grant_seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;

        // Single byte 0x55 from requester 0
        push_req(0, 8'h55, 1'b1, 8'd0, 1'b1);
        drain("single");
        check("single_acks", 32'(ack_cnt[0]), 32'd1);

        // Contention from rr_ptr=0, requester 0 re-requests after its first byte
        do_reset();
        push_req(0, 8'hA0, 1'b1, 8'd0, 1'b1);
        push_req(1, 8'hA1, 1'b1, 8'd0, 1'b1);
        push_req(2, 8'hA2, 1'b1, 8'd0, 1'b1);
        push_req(3, 8'hA3, 1'b1, 8'd0, 1'b1);
        push_req(0, 8'hB0, 1'b1, 8'd0, 1'b1);
        drain("contention");

        // Packet lock: requester 1 waits behind requester 2's three-byte packet
        push_req(2, 8'h11, 1'b0, 8'd0, 1'b1);
        push_req(2, 8'h22, 1'b0, 8'd0, 1'b1);
        push_req(2, 8'h33, 1'b1, 8'd0, 1'b1);
        wait_ack(2, "lock_first_ack");
        push_req(1, 8'h77, 1'b1, 8'd0, 1'b1);
        drain("lock");

        // Packet lock with the owner idling between bytes
        push_req(2, 8'h44, 1'b0, 8'd0, 1'b1);
        push_req(2, 8'h55, 1'b0, 8'd60, 1'b1);
        push_req(2, 8'h66, 1'b1, 8'd60, 1'b1);
        wait_ack(2, "gap_first_ack");
        push_req(1, 8'h78, 1'b1, 8'd0, 1'b1);
        repeat (50) @(negedge clk);
        check("gap_grant_held", 32'(grant), 32'h4);
        check("gap_idle", 32'(busy), 32'd0);
        drain("gap");

        // Constant valid from requester 3: one frame per ack
        push_req(3, 8'hC0, 1'b1, 8'd0, 1'b1);
        push_req(3, 8'hC1, 1'b1, 8'd0, 1'b1);
        push_req(3, 8'hC2, 1'b1, 8'd0, 1'b1);
        drain("hold_valid");

        // Reset during data bit 3; acked byte still finishes on the line
        push_req(0, 8'h5A, 1'b1, 8'd0, 1'b1);
        wait_rdy_low("rst_frame_start");
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_en", 32'(tx_en), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        push_req(1, 8'h3C, 1'b1, 8'd0, 1'b1);
        grant_seen = 1'b0;
        n = 0;
        while (tx_rdy !== 1'b1 && n < 500) begin
            @(negedge clk);
            if (grant != '0) grant_seen = 1'b1;
            n++;
        end
        check("midrst_no_grant", 32'(grant_seen), 32'd0);
        drain("midrst");

        // Valid withdrawn before ack: nothing sent, no ack
        ack2 = ack_cnt[2];
        push_req(0, 8'h81, 1'b1, 8'd0, 1'b1);
        wait_rdy_low("drop_frame_start");
        req_data[23:16] = 8'hEE;
        req_valid[2] = 1'b1;
        repeat (10) @(negedge clk);
        req_valid[2] = 1'b0;
        drain("drop");
        check("drop_no_ack", 32'(ack_cnt[2]), 32'(ack2));

        // Round-robin: rr_ptr=2 after requester 1, so requester 3 beats requester 1
        push_req(1, 8'h91, 1'b1, 8'd0, 1'b1);
        drain("rr_setup");
        push_req(1, 8'h92, 1'b1, 8'd0, 1'b0);
        push_req(3, 8'h93, 1'b1, 8'd0, 1'b0);
        exp_q.push_back(8'h93);
        exp_q.push_back(8'h92);
        drain("rr");

        check("acks_req0", 32'(ack_cnt[0]), 32'd5);
        check("acks_req1", 32'(ack_cnt[1]), 32'd6);
        check("acks_req2", 32'(ack_cnt[2]), 32'd7);
        check("acks_req3", 32'(ack_cnt[3]), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
